// File: rtl/lsu_mem_port.sv
// Load/store access unit: aligns requests to the bus word, builds strobes and lane-shifted
// store data, and sign/zero-extends load data returned over a valid/ready memory port.
module lsu_mem_port #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_wen;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFFW-1:0]   r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [NB-1:0]     r_wstrb;
  logic [XLEN-1:0]   r_rdata;
  logic              r_misalign;

  logic [OFFW-1:0]   w_off;
  logic [OFFW-1:0]   w_align_mask;
  logic [3:0]        w_bytes;
  logic              w_fault;
  logic [NB-1:0]     w_strb;
  logic [XLEN-1:0]   w_bytemask;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rshift;
  logic              w_sign;
  logic [XLEN-1:0]   w_ext;
  logic              w_accept;

  assign w_accept = (r_state == StIdle) && in_valid;

  // Request decode: fault detection, strobes and lane-shifted store data.
  always_comb begin
    w_off   = in_addr[OFFW-1:0];
    w_bytes = 4'd1 << in_size;
    for (int b = 0; b < int'(OFFW); b++) begin
      w_align_mask[b] = (b < int'(in_size));
    end
    w_fault = ((w_off & w_align_mask) != '0) || ((XLEN == 32) && (in_size == 2'd3));
    for (int i = 0; i < int'(NB); i++) begin
      w_strb[i] = in_wen && (i >= int'(w_off)) && (i < int'(w_off) + int'(w_bytes));
      w_bytemask[8*i +: 8] = {8{w_strb[i]}};
    end
    w_wdata = (in_wdata << {w_off, 3'b000}) & w_bytemask;
  end

  // Load extraction: shift addressed lanes down, then extend above the access width.
  always_comb begin
    w_rshift = mem_resp_rdata >> {r_off, 3'b000};
    unique case (r_size)
      2'd0:    w_sign = w_rshift[7];
      2'd1:    w_sign = w_rshift[15];
      2'd2:    w_sign = w_rshift[31];
      default: w_sign = w_rshift[XLEN-1];
    endcase
    for (int i = 0; i < int'(XLEN); i++) begin
      w_ext[i] = (i < (8 << r_size)) ? w_rshift[i] : (w_sign & ~r_unsigned);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = w_fault ? StDone : StReq;
      StReq:   if (mem_req_ready) w_state_next = StWait;
      StWait:  if (mem_resp_valid) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen      <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen      <= in_wen;
        r_size     <= in_size;
        r_unsigned <= in_unsigned;
        r_off      <= w_off;
        r_addr     <= {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        r_wdata    <= w_wdata;
        r_wstrb    <= w_strb;
        r_rdata    <= '0;
        r_misalign <= w_fault;
      end
      if ((r_state == StWait) && mem_resp_valid && !r_wen) begin
        r_rdata <= w_ext;
      end
    end
  end

  assign in_ready      = (r_state == StIdle);
  assign out_valid     = (r_state == StDone);
  assign mem_req_valid = (r_state == StReq);
  assign out_rdata     = r_rdata;
  assign out_misalign  = r_misalign;
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Parametrised, multi-cycle load/store access unit between the NPC memory stage and a valid/ready memory port. It takes one load or store per transaction and aligns the address to the bus word. It generates byte strobes from access size and offset, and shifts store data into the addressed lanes. Load data is extracted and sign- or zero-extended. Misaligned and illegal-size accesses are flagged without touching memory.

## Interface
- XLEN, 64: data width, 32 or 64; byte lanes NB = XLEN/8
- ADDR_W, 64: address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pipeline request valid
- in_ready  out  1  unit can accept a request (IDLE only)
- in_wen  in  1  1 = store, 0 = load
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword
- in_unsigned  in  1  load zero-extends when 1; ignored for stores
- in_addr  in  ADDR_W  byte address
- in_wdata  in  XLEN  store data, right-justified
- out_valid  out  1  result valid
- out_ready  in  1  pipeline accepts result
- out_rdata  out  XLEN  extended load data; 0 for stores and faults
- out_misalign  out  1  access faulted (misaligned or illegal size)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  write request
- mem_req_addr  out  ADDR_W  in_addr with low log2(NB) bits cleared
- mem_req_wdata  out  XLEN  store data shifted to addressed lanes
- mem_req_wstrb  out  NB  byte strobes; all 0 for loads
- mem_resp_valid  in  1  response (read data or write ack), one per request
- mem_resp_rdata  in  XLEN  full bus word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch all request fields.
  - Fault: the offset (addr mod NB) is not a multiple of 2^size, or size=3 with XLEN=32. The unit goes to DONE with out_misalign=1 and raises no memory request.
  - Otherwise the unit goes to REQ.
- REQ: mem_req_valid=1, all mem_req_* held stable. Goes to WAIT on mem_req_ready.
- WAIT: goes to DONE on mem_resp_valid. For loads, the unit latches the extracted data.
- DONE: out_valid=1, out_rdata/out_misalign held stable. Goes to IDLE on out_ready.
- Strobes: 2^size consecutive ones starting at lane = offset.
- Store data: the low 8·2^size bits of in_wdata are shifted left by 8·offset. Non-strobed lanes are 0.
- Load data: mem_resp_rdata is shifted right by 8·offset and truncated to 8·2^size bits. Bit 8·2^size−1 is replicated when in_unsigned=0; otherwise the upper bits are zero-filled. A dword load ignores in_unsigned.
- mem_resp_valid outside WAIT is ignored.
- in_valid outside IDLE is ignored (in_ready=0).

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_rdata=0, out_misalign=0, mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0.
- Reset takes effect immediately and from any state. Asserting rst in REQ or WAIT drops mem_req_valid asynchronously. Any late response is ignored because the unit is in IDLE.
- Accept at edge N:
  - mem_req_valid is high from cycle N+1.
  - Earliest response is cycle N+2.
  - out_valid is high from cycle N+3; this is the minimum load-to-result latency.
- A fault accepted at edge N gives out_valid at N+1 with mem_req_valid never asserted.
- At most one transaction is in flight. The next accept occurs no earlier than the cycle after the out_valid&&out_ready handshake.
- A response arriving in the same cycle as the request handshake is not permitted by the port protocol. The unit samples responses only in WAIT.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Store byte, XLEN=64, addr=0x80000003, wdata=0x1122_33AB → mem_req_addr=0x80000000, wstrb=0x08, wdata=0x00000000_AB000000, wen=1. After ack: out_valid, out_rdata=0, out_misalign=0.
- Signed half load, addr=0x80000006, mem_resp_rdata=0x8001_0000_0000_0000 → out_rdata=0xFFFFFFFF_FFFF8001. Resp at N+2 gives out_valid at N+3.
- Unsigned word load, addr=0x80000004, rdata=0xDEADBEEF_12345678 → out_rdata=0x00000000_DEADBEEF. The same access with in_unsigned=0 → 0xFFFFFFFF_DEADBEEF.
- Misaligned word load at addr=0x80000002 → mem_req_valid never rises, out_valid at N+1, out_misalign=1, out_rdata=0. A dword access with XLEN=32 gives the same result.
- Backpressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles → mem_req_* and out_* stable throughout. in_ready stays 0 and a second in_valid is not accepted.
- Assert rst while in WAIT, then drive mem_resp_valid after release → all outputs go to their reset values immediately, in_ready=1, and the stale response produces no out_valid.
